// File: rtl/tone_pkg.sv
// Shared constants, note period table and FSM state type for the tone decoder.
package tone_pkg;

  localparam int NOTE_COUNT = 16;
  localparam int PERIOD_W   = 20;
  localparam int TOL_SHIFT  = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Nominal rising-edge period (50 MHz clocks) for each note, low to high pitch.
  function automatic logic [PERIOD_W-1:0] nom_period(input logic [3:0] idx);
    logic [PERIOD_W-1:0] p;
    case (idx)
      4'd0:    p = 20'd303373;
      4'd1:    p = 20'd255105;
      4'd2:    p = 20'd227273;
      4'd3:    p = 20'd202477;
      4'd4:    p = 20'd191113;
      4'd5:    p = 20'd170263;
      4'd6:    p = 20'd151687;
      4'd7:    p = 20'd143173;
      4'd8:    p = 20'd127553;
      4'd9:    p = 20'd113637;
      4'd10:   p = 20'd101239;
      4'd11:   p = 20'd95557;
      4'd12:   p = 20'd85132;
      4'd13:   p = 20'd75844;
      4'd14:   p = 20'd63777;
      default: p = 20'd56819;
    endcase
    return p;
  endfunction

  // Returns {hit, idx}: hit when the period is within nom>>TOL_SHIFT of a table entry.
  // Tolerance windows are far narrower than the note spacing, so at most one entry hits.
  function automatic logic [4:0] note_lookup(input logic [PERIOD_W-1:0] p);
    logic [PERIOD_W-1:0] nom;
    logic [PERIOD_W-1:0] diff;
    logic [4:0]          r;
    r = '0;
    for (int i = 0; i < NOTE_COUNT; i++) begin
      nom  = nom_period(4'(i));
      diff = (p > nom) ? (p - nom) : (nom - p);
      if (diff <= (nom >> TOL_SHIFT)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Synchronizes the asynchronous tone input and emits a one-clock pulse per
// rising edge. Build option TONE_DEC_GLITCH_FILTER_EN adds a 3-sample majority
// filter (edge latency 5 clk instead of 3, rejects pulses of 1 clk or less).
module tone_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic rise
);

  logic s1, s2, lvl, lvl_d;

  // Two-flop synchronizer for the asynchronous tone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
    end
  end

`ifdef TONE_DEC_GLITCH_FILTER_EN
  logic h1, h2;

  // Majority of the last three synchronized samples; a lone sample cannot flip the level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1  <= 1'b0;
      h2  <= 1'b0;
      lvl <= 1'b0;
    end else begin
      h1  <= s2;
      h2  <= h1;
      lvl <= (s2 & h1) | (s2 & h2) | (h1 & h2);
    end
  end
`else
  assign lvl = s2;
`endif

  // Registered rising-edge detect on the (optionally filtered) level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_d <= 1'b0;
      rise  <= 1'b0;
    end else begin
      lvl_d <= lvl;
      rise  <= lvl & ~lvl_d;
    end
  end

endmodule

// File: rtl/tone_decoder.sv
// Square-wave note decoder: measures rising-edge periods, matches them against
// the note table and locks after MATCH_CNT consecutive agreeing periods.
// Optional build macro TONE_DEC_GLITCH_FILTER_EN (see tone_edge_sync).
module tone_decoder
  import tone_pkg::*;
#(
  parameter int                  MATCH_CNT = 2,
  parameter logic [PERIOD_W-1:0] TIMEOUT   = 20'd400000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tone_in,
  output logic [3:0]          note_idx,
  output logic                note_valid,
  output logic                note_strobe,
  output logic [PERIOD_W-1:0] period
);

  localparam logic [2:0] MATCH_N = 3'(MATCH_CNT);

  state_t              state;
  logic                rise;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] meas;
  logic [2:0]          mcnt, mcnt_n;
  logic [3:0]          prev_cand;
  logic                prev_ok;
  logic [4:0]          look;
  logic                cand_hit;
  logic [3:0]          cand_idx;
  logic                tmo;

  tone_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .tone_in (tone_in),
    .rise    (rise)
  );

  // Period seen by an edge this cycle includes the edge cycle itself
  always_comb begin
    meas     = (cnt >= TIMEOUT) ? TIMEOUT : cnt + 20'd1;
    look     = note_lookup(meas);
    cand_hit = look[4];
    cand_idx = look[3:0];
    // An edge on the timeout cycle wins over the timeout
    tmo      = !rise && (cnt == TIMEOUT - 20'd1);
    mcnt_n   = '0;
    if (cand_hit)
      mcnt_n = (prev_ok && cand_idx == prev_cand) ? mcnt + 3'd1 : 3'd1;
  end

  // Edge-to-edge cycle counter, saturating at TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (rise)           cnt <= '0;
    else if (cnt != TIMEOUT) cnt <= cnt + 20'd1;
  end

  // Lock FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      mcnt        <= '0;
      prev_cand   <= '0;
      prev_ok     <= 1'b0;
      note_idx    <= '0;
      note_valid  <= 1'b0;
      note_strobe <= 1'b0;
      period      <= '0;
    end else begin
      note_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          // First edge only starts a measurement; no period exists yet
          if (rise) begin
            state   <= ST_MEASURE;
            mcnt    <= '0;
            prev_ok <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            period    <= meas;
            mcnt      <= mcnt_n;
            prev_cand <= cand_idx;
            prev_ok   <= cand_hit;
            if (cand_hit && mcnt_n == MATCH_N) begin
              state       <= ST_LOCKED;
              note_idx    <= cand_idx;
              note_valid  <= 1'b1;
              note_strobe <= 1'b1;
            end
          end else if (tmo) begin
            state      <= ST_IDLE;
            note_valid <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (rise) begin
            period <= meas;
            // Any disagreement restarts matching; note_idx keeps the last note
            if (!(cand_hit && cand_idx == note_idx)) begin
              state      <= ST_MEASURE;
              note_valid <= 1'b0;
              mcnt       <= cand_hit ? 3'd1 : 3'd0;
              prev_cand  <= cand_idx;
              prev_ok    <= cand_hit;
            end
          end else if (tmo) begin
            state      <= ST_IDLE;
            note_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder: drives square waves, scoreboards the
// expected lock strobes (note and cycle) and checks levels between edges.
module tb_tone_decoder;
  import tone_pkg::*;

  localparam int TMO = 400000;
`ifdef TONE_DEC_GLITCH_FILTER_EN
  localparam int LAT = 6;
  localparam bit GL  = 1'b1;
`else
  localparam int LAT = 4;
  localparam bit GL  = 1'b0;
`endif

  typedef struct {
    logic [3:0] idx;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tone_in;
  logic [3:0]  note_idx;
  logic        note_valid;
  logic        note_strobe;
  logic [19:0] period;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   last_rise = 0;
  logic strobe_q = 1'b0;
  exp_t sb[$];

  tone_decoder #(.MATCH_CNT(2), .TIMEOUT(20'(TMO))) dut (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .note_idx    (note_idx),
    .note_valid  (note_valid),
    .note_strobe (note_strobe),
    .period      (period)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One tone period of n clocks starting with a rise; optional 1-clk glitch in the low phase
  task automatic pulse(input int n, input bit lock, input logic [3:0] idx, input bit glitch);
    exp_t e;
    @(negedge clk);
    tone_in   = 1'b1;
    last_rise = cyc;
    if (lock) begin
      e.idx = idx;
      e.cyc = cyc + LAT;
      sb.push_back(e);
    end
    repeat (n / 2) @(negedge clk);
    tone_in = 1'b0;
    if (glitch) begin
      repeat (n / 4) @(negedge clk);
      tone_in = 1'b1;
      @(negedge clk);
      tone_in = 1'b0;
      repeat (n - n / 2 - n / 4 - 2) @(negedge clk);
    end else begin
      repeat (n - n / 2 - 1) @(negedge clk);
    end
  endtask

  // Strobe monitor: every strobe must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (note_strobe) begin
        chk("strobe_2cyc", 32'(strobe_q), 0);
        if (sb.size() == 0) begin
          chk("strobe_unexp", 32'(note_strobe), 0);
        end else begin
          e = sb.pop_front();
          chk("strobe_idx", 32'(note_idx), 32'(e.idx));
          chk("strobe_cyc", cyc, e.cyc);
          chk("strobe_valid", 32'(note_valid), 1);
        end
      end
      strobe_q = note_strobe;
    end
  end

  initial begin
    exp_t e;
    rst     = 1'b1;
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idx", 32'(note_idx), 0);
    chk("rst_valid", 32'(note_valid), 0);
    chk("rst_strobe", 32'(note_strobe), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Lock on idx 9 after two full matching periods
    pulse(113637, 1'b0, 4'd0, 1'b0);
    chk("n9_first_valid", 32'(note_valid), 0);
    pulse(113637, 1'b0, 4'd0, 1'b0);
    chk("n9_one_valid", 32'(note_valid), 0);
    chk("n9_one_period", 32'(period), 113637);
    pulse(101239, 1'b1, 4'd9, 1'b0);
    chk("n9_lock_valid", 32'(note_valid), 1);
    chk("n9_lock_idx", 32'(note_idx), 9);
    chk("n9_lock_period", 32'(period), 113637);

    // Switch to idx 10: drop on first new edge holding idx 9, relock next edge
    pulse(101239, 1'b0, 4'd0, 1'b0);
    chk("n10_drop_valid", 32'(note_valid), 0);
    chk("n10_drop_idx", 32'(note_idx), 9);
    chk("n10_drop_period", 32'(period), 101239);
    pulse(101239, 1'b1, 4'd10, 1'b0);
    chk("n10_lock_valid", 32'(note_valid), 1);
    chk("n10_lock_idx", 32'(note_idx), 10);

    // Out-of-tolerance period (+1900 vs tol 1775) is non-matching
    pulse(115537, 1'b0, 4'd0, 1'b0);
    chk("n10_hold_valid", 32'(note_valid), 1);
    pulse(56819, 1'b0, 4'd0, 1'b0);
    chk("oot_valid", 32'(note_valid), 0);
    chk("oot_period", 32'(period), 115537);
    pulse(56819, 1'b0, 4'd0, 1'b0);
    chk("n15_one_valid", 32'(note_valid), 0);

    // Lock idx 15, then reset mid-period
    @(negedge clk);
    tone_in = 1'b1;
    e.idx   = 4'd15;
    e.cyc   = cyc + LAT;
    sb.push_back(e);
    repeat (1000) @(negedge clk);
    chk("n15_lock_valid", 32'(note_valid), 1);
    chk("n15_lock_idx", 32'(note_idx), 15);
    rst = 1'b1;
    #1;
    chk("arst_idx", 32'(note_idx), 0);
    chk("arst_valid", 32'(note_valid), 0);
    chk("arst_strobe", 32'(note_strobe), 0);
    chk("arst_period", 32'(period), 0);
    @(negedge clk);
    tone_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Relock needs a fresh first edge plus two periods (glitch in filter build)
    pulse(56819, 1'b0, 4'd0, 1'b0);
    chk("re_first_valid", 32'(note_valid), 0);
    pulse(56819, 1'b0, 4'd0, GL);
    chk("re_one_valid", 32'(note_valid), 0);
    chk("re_one_period", 32'(period), 56819);
    pulse(56819, 1'b1, 4'd15, 1'b0);
    chk("re_lock_valid", 32'(note_valid), 1);
    chk("re_lock_idx", 32'(note_idx), 15);
    chk("re_lock_period", 32'(period), 56819);

    // Silence: note_valid falls exactly TIMEOUT clocks after the last edge
    while (cyc < last_rise + LAT + TMO - 1) @(negedge clk);
    chk("tmo_before_valid", 32'(note_valid), 1);
    @(negedge clk);
    chk("tmo_valid", 32'(note_valid), 0);
    chk("tmo_state", 32'(dut.state), 32'(ST_IDLE));
    chk("tmo_period", 32'(period), 56819);

    repeat (4) @(negedge clk);
    chk("strobe_missing", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
